// File: rtl/hilo_mul_issuer_if.sv
// hilo_mul_issuer_if: handshake and data bundle between the HI/LO issuer and
// the multiplier.
//   master (issuer):     drives mulReq, mul_cancel, isSignedMul, isAccumlate,
//                        add_sub_op, mulOprand, HiLoData; samples
//                        mulOprand_ok, mulData_ok, mulRes.
//   slave (multiplier):  the mirror image.
interface hilo_mul_issuer_if;
    logic        mulReq;
    logic        mul_cancel;
    logic        isSignedMul;
    logic        isAccumlate;
    logic        add_sub_op;
    logic [63:0] mulOprand;
    logic [63:0] HiLoData;
    logic        mulOprand_ok;
    logic        mulData_ok;
    logic [63:0] mulRes;

    modport master (
        output mulReq, mul_cancel, isSignedMul, isAccumlate, add_sub_op,
               mulOprand, HiLoData,
        input  mulOprand_ok, mulData_ok, mulRes
    );

    modport slave (
        input  mulReq, mul_cancel, isSignedMul, isAccumlate, add_sub_op,
               mulOprand, HiLoData,
        output mulOprand_ok, mulData_ok, mulRes
    );
endinterface

// File: rtl/hilo_mul_issuer.sv
// hilo_mul_issuer: owns the architectural HI/LO registers, launches one
// multiply at a time towards the multiplier and commits its result.
//   clk, rst         clock, asynchronous active-low reset
//   op_valid/op_code/op_a/op_b, op_ready   op intake from EXE
//   flush            pipeline flush (cancels any in-flight multiply)
//   rd_req/rd_sel, rd_data/rd_stall        MFHI/MFLO read port
//   busy             a multiply is in flight
//   mif (master)     multiplier request/cancel/result handshake
//   hi, lo           architectural registers
// Build option: HILO_RESULT_FWD_EN forwards the committing result to a read
// in the commit cycle instead of stalling it one more cycle.
module hilo_mul_issuer #(
    parameter int unsigned OPW = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_valid,
    input  logic [OPW-1:0]        op_code,
    input  logic [31:0]           op_a,
    input  logic [31:0]           op_b,
    output logic                  op_ready,
    input  logic                  flush,
    input  logic                  rd_req,
    input  logic                  rd_sel,
    output logic [31:0]           rd_data,
    output logic                  rd_stall,
    output logic                  busy,
    hilo_mul_issuer_if.master     mif,
    output logic [31:0]           hi,
    output logic [31:0]           lo
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] BUSY = 2'd2;

    localparam logic [OPW-1:0] OP_MULT  = OPW'(1);
    localparam logic [OPW-1:0] OP_MULTU = OPW'(2);
    localparam logic [OPW-1:0] OP_MADD  = OPW'(3);
    localparam logic [OPW-1:0] OP_MADDU = OPW'(4);
    localparam logic [OPW-1:0] OP_MSUB  = OPW'(5);
    localparam logic [OPW-1:0] OP_MSUBU = OPW'(6);
    localparam logic [OPW-1:0] OP_MTHI  = OPW'(7);
    localparam logic [OPW-1:0] OP_MTLO  = OPW'(8);

    logic [1:0]  state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic        sgn_q, sgn_d;
    logic        acc_q, acc_d;
    logic        addsub_q, addsub_d;
    logic        mul_req_q, mul_req_d;

    logic        take_c;
    logic        is_mul_c;
    logic        commit_c;

    // Op decode
    always_comb begin
        is_mul_c = (op_code == OP_MULT)  || (op_code == OP_MULTU) ||
                   (op_code == OP_MADD)  || (op_code == OP_MADDU) ||
                   (op_code == OP_MSUB)  || (op_code == OP_MSUBU);
        take_c   = op_valid && op_ready && !flush;
        commit_c = (state_q == BUSY) && mif.mulData_ok && !flush;
    end

    // Next-state and register-update logic
    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        sgn_d    = sgn_q;
        acc_d    = acc_q;
        addsub_d = addsub_q;

        case (state_q)
            IDLE: begin
                if (take_c) begin
                    if (is_mul_c) begin
                        opa_d    = op_a;
                        opb_d    = op_b;
                        sgn_d    = (op_code == OP_MULT) || (op_code == OP_MADD) ||
                                   (op_code == OP_MSUB);
                        acc_d    = (op_code == OP_MADD) || (op_code == OP_MADDU) ||
                                   (op_code == OP_MSUB) || (op_code == OP_MSUBU);
                        addsub_d = (op_code == OP_MADD) || (op_code == OP_MADDU);
                        state_d  = REQ;
                    end else if (op_code == OP_MTHI) begin
                        hi_d = op_a;
                    end else if (op_code == OP_MTLO) begin
                        lo_d = op_a;
                    end
                end
            end
            REQ: begin
                // flush wins over a coincident acceptance
                if (flush) begin
                    state_d = IDLE;
                end else if (mif.mulOprand_ok) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (mif.mulData_ok) begin
                    hi_d    = mif.mulRes[63:32];
                    lo_d    = mif.mulRes[31:0];
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        mul_req_d = (state_d == REQ);
    end

    // State and data registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            opa_q     <= 32'd0;
            opb_q     <= 32'd0;
            sgn_q     <= 1'b0;
            acc_q     <= 1'b0;
            addsub_q  <= 1'b0;
            mul_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            sgn_q     <= sgn_d;
            acc_q     <= acc_d;
            addsub_q  <= addsub_d;
            mul_req_q <= mul_req_d;
        end
    end

    // Status, multiplier-side and read-port outputs
    always_comb begin
        op_ready        = (state_q == IDLE);
        busy            = (state_q != IDLE);
        hi              = hi_q;
        lo              = lo_q;
        mif.mulReq      = mul_req_q;
        mif.mul_cancel  = flush && (state_q != IDLE);
        mif.isSignedMul = sgn_q;
        mif.isAccumlate = acc_q;
        mif.add_sub_op  = addsub_q;
        mif.mulOprand   = {opb_q, opa_q};
        // the multiplier samples HiLoData while accumulating, so hi/lo are
        // only ever written from IDLE or at the commit edge
        mif.HiLoData    = {hi_q, lo_q};
`ifdef HILO_RESULT_FWD_EN
        if (commit_c) begin
            rd_stall = 1'b0;
            rd_data  = rd_sel ? mif.mulRes[63:32] : mif.mulRes[31:0];
        end else begin
            rd_stall = rd_req && (state_q != IDLE);
            rd_data  = rd_sel ? hi_q : lo_q;
        end
`else
        rd_stall = rd_req && (state_q != IDLE);
        rd_data  = rd_sel ? hi_q : lo_q;
`endif
    end

endmodule

// File: tb/tb_hilo_mul_issuer.sv
// tb_hilo_mul_issuer: directed vector table, hand-written flush/read/reset
// sequences and a randomized run against an arithmetic HI/LO model.
module tb_hilo_mul_issuer;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [3:0]  op_code;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_ready;
    logic        flush;
    logic        rd_req;
    logic        rd_sel;
    logic [31:0] rd_data;
    logic        rd_stall;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    hilo_mul_issuer_if mif();

    hilo_mul_issuer #(.OPW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op_code  (op_code),
        .op_a     (op_a),
        .op_b     (op_b),
        .op_ready (op_ready),
        .flush    (flush),
        .rd_req   (rd_req),
        .rd_sel   (rd_sel),
        .rd_data  (rd_data),
        .rd_stall (rd_stall),
        .busy     (busy),
        .mif      (mif.master),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  code;
        logic [31:0] a, b, hi0, lo0;
        logic        sgn, acc, addsub;
        logic [31:0] ehi, elo;
    } vec_t;

    vec_t        vecs[6];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_hi, ref_lo;
    logic [63:0] res;
    logic        fl, exp_stall;
    logic [3:0]  code;
    logic [31:0] ra, rb;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_in();
        op_valid = 1'b0; op_code = 4'd0; op_a = 32'd0; op_b = 32'd0;
        flush = 1'b0; rd_req = 1'b0; rd_sel = 1'b0;
        mif.mulOprand_ok = 1'b0; mif.mulData_ok = 1'b0; mif.mulRes = 64'd0;
    endtask

    // Behavioural multiplier: product (signed or not) optionally folded into {hi,lo}
    function automatic logic [63:0] mul_model(input logic [3:0] c, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] hl);
        logic [63:0] p;
        if (c == 4'd1 || c == 4'd3 || c == 4'd5)
            p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        else
            p = {32'd0, a} * {32'd0, b};
        if (c == 4'd3 || c == 4'd4) return hl + p;
        if (c == 4'd5 || c == 4'd6) return hl - p;
        return p;
    endfunction

    task automatic mt(input logic to_hi, input logic [31:0] v);
        op_valid = 1'b1; op_code = to_hi ? 4'd7 : 4'd8; op_a = v;
        tick();
        op_valid = 1'b0; op_code = 4'd0;
    endtask

    // Issue a multiply op from IDLE; returns at the first REQ cycle
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        op_valid = 1'b1; op_code = c; op_a = a; op_b = b;
        tick();
        op_valid = 1'b0; op_code = 4'd0;
    endtask

    task automatic run_vec(input vec_t v);
        mt(1'b1, v.hi0);
        mt(1'b0, v.lo0);
        #1 chk("pre_hilo", {hi, lo}, {v.hi0, v.lo0});
        issue(v.code, v.a, v.b);
        #1;
        chk("vec_mulReq", mif.mulReq, 1'b1);
        chk("vec_signed", mif.isSignedMul, v.sgn);
        chk("vec_accum", mif.isAccumlate, v.acc);
        chk("vec_addsub", mif.add_sub_op, v.addsub);
        chk("vec_oprand", mif.mulOprand, {v.b, v.a});
        chk("vec_ready_lo", op_ready, 1'b0);
        tick();
        #1 chk("vec_req_hold", mif.mulReq, 1'b1);
        mif.mulOprand_ok = 1'b1;
        tick();
        mif.mulOprand_ok = 1'b0;
        #1;
        chk("vec_req_drop", mif.mulReq, 1'b0);
        chk("vec_busy", busy, 1'b1);
        for (int k = 0; k < (v.acc ? 3 : 1); k++) begin
            chk("vec_hilo_stable", mif.HiLoData, {v.hi0, v.lo0});
            tick();
            #1;
        end
        mif.mulData_ok = 1'b1; mif.mulRes = {v.ehi, v.elo};
        #1 chk("vec_hilo_at_ok", mif.HiLoData, {v.hi0, v.lo0});
        tick();
        mif.mulData_ok = 1'b0; mif.mulRes = 64'd0;
        #1;
        chk("vec_commit", {hi, lo}, {v.ehi, v.elo});
        chk("vec_ready", op_ready, 1'b1);
    endtask

    task automatic rand_read();
        rd_req = 1'($urandom_range(0, 1));
        rd_sel = 1'($urandom_range(0, 1));
        // ops presented while not ready must be ignored
        op_valid = 1'($urandom_range(0, 1));
        op_code  = 4'($urandom_range(0, 15));
        op_a     = $urandom;
    endtask

    initial begin
        vecs[0] = '{4'd1, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0,   1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[1] = '{4'd2, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0,   1'b0, 1'b0, 1'b0, 32'h00000001, 32'hFFFFFFFE};
        vecs[2] = '{4'd3, 32'hFFFFFFFD, 32'd4, 32'd0, 32'd100, 1'b1, 1'b1, 1'b1, 32'h00000000, 32'h00000058};
        vecs[3] = '{4'd4, 32'd3,        32'd4, 32'd0, 32'd10,  1'b0, 1'b1, 1'b1, 32'h00000000, 32'h00000016};
        vecs[4] = '{4'd5, 32'd2,        32'd3, 32'd0, 32'd5,   1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[5] = '{4'd6, 32'd2,        32'd3, 32'd1, 32'd0,   1'b0, 1'b1, 1'b0, 32'h00000000, 32'hFFFFFFFA};

        idle_in();
        rst = 1'b0;
        tick();
        tick();
        flush = 1'b1; rd_req = 1'b1;
        #1;
        chk("rst_ready", op_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mulReq", mif.mulReq, 1'b0);
        chk("rst_cancel", mif.mul_cancel, 1'b0);
        chk("rst_stall", rd_stall, 1'b0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_attr", {mif.isSignedMul, mif.isAccumlate, mif.add_sub_op}, 3'b000);
        idle_in();
        rst = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // flush in IDLE drops the op
        mt(1'b1, 32'h11); mt(1'b0, 32'h22);
        op_valid = 1'b1; op_code = 4'd1; op_a = 32'd3; op_b = 32'd3; flush = 1'b1;
        #1 chk("fl_idle_cancel", mif.mul_cancel, 1'b0);
        tick();
        op_valid = 1'b0; flush = 1'b0;
        #1 chk("fl_idle_busy", busy, 1'b0);
        op_valid = 1'b1; op_code = 4'd7; op_a = 32'h99; flush = 1'b1;
        tick();
        op_valid = 1'b0; flush = 1'b0;
        #1 chk("fl_idle_mthi", hi, 32'h11);

        // flush in REQ wins over a coincident acceptance
        issue(4'd1, 32'd7, 32'd9);
        mif.mulOprand_ok = 1'b1; flush = 1'b1;
        #1 chk("fl_req_cancel", mif.mul_cancel, 1'b1);
        tick();
        mif.mulOprand_ok = 1'b0; flush = 1'b0;
        #1;
        chk("fl_req_idle", op_ready, 1'b1);
        chk("fl_req_mulReq", mif.mulReq, 1'b0);

        // flush in BUSY wins over a coincident result
        issue(4'd2, 32'd7, 32'd9);
        mif.mulOprand_ok = 1'b1;
        tick();
        mif.mulOprand_ok = 1'b0;
        mif.mulData_ok = 1'b1; mif.mulRes = 64'hDEAD_BEEF_0BAD_F00D; flush = 1'b1;
        #1 chk("fl_busy_cancel", mif.mul_cancel, 1'b1);
        tick();
        idle_in();
        #1;
        chk("fl_busy_ready", op_ready, 1'b1);
        chk("fl_busy_hilo", {hi, lo}, {32'h11, 32'h22});

        // MFLO while a multiply is in flight
        mt(1'b0, 32'd7);
        issue(4'd2, 32'd5, 32'd6);
        mif.mulOprand_ok = 1'b1;
        tick();
        mif.mulOprand_ok = 1'b0;
        rd_req = 1'b1; rd_sel = 1'b0;
        #1 chk("rd_busy_stall", rd_stall, 1'b1);
        tick();
        mif.mulData_ok = 1'b1; mif.mulRes = {32'd0, 32'd30};
        #1;
`ifdef HILO_RESULT_FWD_EN
        chk("rd_commit_stall", rd_stall, 1'b0);
        chk("rd_commit_data", rd_data, 32'd30);
`else
        chk("rd_commit_stall", rd_stall, 1'b1);
`endif
        tick();
        mif.mulData_ok = 1'b0;
        #1;
        chk("rd_after_stall", rd_stall, 1'b0);
        chk("rd_after_data", rd_data, 32'd30);
        idle_in();

        // async reset in the middle of REQ
        mt(1'b1, 32'h55);
        issue(4'd1, 32'd1, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_mulReq", mif.mulReq, 1'b0);
        chk("arst_hilo", {hi, lo}, 64'd0);
        chk("arst_ready", op_ready, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // randomized run against the arithmetic model
        ref_hi = 32'd0; ref_lo = 32'd0;
        for (int it = 0; it < 80; it++) begin
            code = 4'($urandom_range(0, 15));
            ra = $urandom; rb = $urandom;
            if ($urandom_range(0, 1) == 1) ra = 32'($urandom_range(0, 9));
            fl = ($urandom_range(0, 7) == 0);
            rd_req = 1'($urandom_range(0, 1)); rd_sel = 1'($urandom_range(0, 1));
            op_valid = 1'b1; op_code = code; op_a = ra; op_b = rb; flush = fl;
            #1;
            chk("r_ready", op_ready, 1'b1);
            chk("r_idle_cancel", mif.mul_cancel, 1'b0);
            chk("r_idle_stall", rd_stall, 1'b0);
            chk("r_idle_rd", rd_data, rd_sel ? ref_hi : ref_lo);
            tick();
            op_valid = 1'b0; flush = 1'b0;
            if (!fl && code == 4'd7) ref_hi = ra;
            if (!fl && code == 4'd8) ref_lo = ra;
            if (!fl && code >= 4'd1 && code <= 4'd6) begin
                res = mul_model(code, ra, rb, {ref_hi, ref_lo});
                for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                    rand_read();
                    #1;
                    chk("r_req", mif.mulReq, 1'b1);
                    chk("r_req_stall", rd_stall, rd_req);
                    chk("r_req_hilo", mif.HiLoData, {ref_hi, ref_lo});
                    tick();
                end
                rand_read();
                fl = ($urandom_range(0, 5) == 0);
                mif.mulOprand_ok = 1'b1; flush = fl;
                #1;
                chk("r_acc_req", mif.mulReq, 1'b1);
                chk("r_acc_cancel", mif.mul_cancel, fl);
                chk("r_acc_oprand", mif.mulOprand, {rb, ra});
                tick();
                mif.mulOprand_ok = 1'b0; flush = 1'b0;
                if (!fl) begin
                    for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                        rand_read();
                        #1;
                        chk("r_busy", busy, 1'b1);
                        chk("r_busy_req", mif.mulReq, 1'b0);
                        chk("r_busy_stall", rd_stall, rd_req);
                        chk("r_busy_hilo", mif.HiLoData, {ref_hi, ref_lo});
                        tick();
                    end
                    rand_read();
                    fl = ($urandom_range(0, 5) == 0);
                    mif.mulData_ok = 1'b1; mif.mulRes = res; flush = fl;
`ifdef HILO_RESULT_FWD_EN
                    exp_stall = rd_req && fl;
`else
                    exp_stall = rd_req;
`endif
                    #1;
                    chk("r_cm_cancel", mif.mul_cancel, fl);
                    chk("r_cm_stall", rd_stall, exp_stall);
`ifdef HILO_RESULT_FWD_EN
                    if (rd_req && !fl)
                        chk("r_cm_fwd", rd_data, rd_sel ? res[63:32] : res[31:0]);
`endif
                    tick();
                    mif.mulData_ok = 1'b0; mif.mulRes = {$urandom, $urandom}; flush = 1'b0;
                    if (!fl) begin
                        ref_hi = res[63:32];
                        ref_lo = res[31:0];
                    end
                end
            end
            op_valid = 1'b0;
            #1;
            chk("r_end_busy", busy, 1'b0);
            chk("r_end_hilo", {hi, lo}, {ref_hi, ref_lo});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so a stuck handshake can never hang the run
    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
